// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/writeback controller for the ALU datapath.
// Decodes 16-bit instructions into ALU op, register selects and immediate; owns the PC.
module alu_ctrl_fsm #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             fetch_req,
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       alucont,
  output logic [3:0]       rdest_sel,
  output logic [3:0]       rsrc_sel,
  output logic [WIDTH-1:0] imm,
  output logic             src_is_imm,
  output logic             reg_we,
  output logic             psr_we,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] ir_reg;
  logic [WIDTH-1:0] pc_reg;
  logic [3:0]       alucont_reg, rdest_reg, rsrc_reg;
  logic [WIDTH-1:0] imm_reg;
  logic             src_imm_reg, legal_reg, wr_reg_reg, wr_psr_reg;

  logic [3:0]       opcode, ext;
  logic [4:0]       arith_op, arith_ext;
  logic             dec_legal, dec_src_imm, dec_wr_reg, dec_wr_psr;
  logic [3:0]       dec_alucont;
  logic [WIDTH-1:0] dec_imm;

  // The arithmetic/logic group shares one code space: ext in register form, opcode in immediate form.
  function automatic logic [4:0] alu_code(input logic [3:0] c);
    case (c)
      4'b0101: alu_code = {1'b1, 4'b0000};  // ADD
      4'b1001: alu_code = {1'b1, 4'b0001};  // SUB
      4'b0001: alu_code = {1'b1, 4'b0010};  // AND
      4'b0011: alu_code = {1'b1, 4'b0011};  // XOR
      4'b0010: alu_code = {1'b1, 4'b0100};  // OR
      4'b1011: alu_code = {1'b1, 4'b0101};  // CMP
      4'b1101: alu_code = {1'b1, 4'b0110};  // MOV
      default: alu_code = 5'b0;
    endcase
  endfunction

  always_comb begin
    opcode      = ir_reg[15:12];
    ext         = ir_reg[7:4];
    arith_op    = alu_code(opcode);
    arith_ext   = alu_code(ext);
    dec_legal   = 1'b0;
    dec_alucont = 4'b0000;
    dec_src_imm = 1'b0;
    dec_imm     = '0;
    if (opcode == 4'b0000) begin
      dec_legal   = arith_ext[4];
      dec_alucont = arith_ext[3:0];
    end else if (arith_op[4]) begin
      dec_legal   = 1'b1;
      dec_alucont = arith_op[3:0];
      dec_src_imm = 1'b1;
      if (opcode == 4'b0001 || opcode == 4'b0010 || opcode == 4'b0011)
        dec_imm[7:0] = ir_reg[7:0];
      else
        dec_imm = {{(WIDTH-8){ir_reg[7]}}, ir_reg[7:0]};
    end else if (opcode == 4'b1000 && ext == 4'b0100) begin
      dec_legal   = 1'b1;
      dec_alucont = 4'b0111;
    end else if (opcode == 4'b1000 && ext[3:1] == 3'b000) begin
      dec_legal    = 1'b1;
      dec_alucont  = 4'b1000;
      dec_src_imm  = 1'b1;
      dec_imm[4:0] = ir_reg[4:0];
    end else if (opcode == 4'b1111) begin
      dec_legal     = 1'b1;
      dec_alucont   = 4'b1001;
      dec_src_imm   = 1'b1;
      dec_imm[15:8] = ir_reg[7:0];
    end
    // Only ADD/SUB/CMP touch flags; CMP is the one op that leaves the register file alone.
    dec_wr_psr = dec_legal && (dec_alucont == 4'b0000 || dec_alucont == 4'b0001 ||
                               dec_alucont == 4'b0101);
    dec_wr_reg = dec_legal && (dec_alucont != 4'b0101);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH;
      ir_reg      <= '0;
      pc_reg      <= RESET_PC;
      alucont_reg <= 4'b0000;
      rdest_reg   <= 4'b0000;
      rsrc_reg    <= 4'b0000;
      imm_reg     <= '0;
      src_imm_reg <= 1'b0;
      legal_reg   <= 1'b0;
      wr_reg_reg  <= 1'b0;
      wr_psr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH && instr_valid)
        ir_reg <= instr;
      if (state_reg == DECODE) begin
        alucont_reg <= dec_alucont;
        rdest_reg   <= ir_reg[11:8];
        rsrc_reg    <= ir_reg[3:0];
        imm_reg     <= dec_imm;
        src_imm_reg <= dec_src_imm;
        legal_reg   <= dec_legal;
        wr_reg_reg  <= dec_wr_reg;
        wr_psr_reg  <= dec_wr_psr;
      end
      if (state_reg == WB)
        pc_reg <= pc_reg + WIDTH'(1);
    end
  end

  // Strobes are gated by reset so an abort in WB suppresses that cycle's writeback.
  always_comb begin
    state_next = state_reg;
    fetch_req  = 1'b0;
    reg_we     = 1'b0;
    psr_we     = 1'b0;
    illegal    = 1'b0;
    busy       = (state_reg != FETCH);
    case (state_reg)
      FETCH: begin
        fetch_req = !reset;
        if (instr_valid) state_next = DECODE;
      end
      DECODE: state_next = dec_legal ? EXEC : WB;
      EXEC:   state_next = WB;
      WB: begin
        state_next = FETCH;
        reg_we     = !reset && wr_reg_reg;
        psr_we     = !reset && wr_psr_reg;
        illegal    = !reset && !legal_reg;
      end
      default: state_next = FETCH;
    endcase
  end

  assign pc         = pc_reg;
  assign alucont    = alucont_reg;
  assign rdest_sel  = rdest_reg;
  assign rsrc_sel   = rsrc_reg;
  assign imm        = imm_reg;
  assign src_is_imm = src_imm_reg;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Randomized bench for alu_ctrl_fsm: each instruction is checked against a table-driven
// reference decode, with PC tracking, latency, strobe, handshake and reset-abort checks.
module tb_alu_ctrl_fsm;
  localparam logic [15:0] RPC = 16'hFFF8;  // close to the top so the PC wrap is exercised

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [3:0]  alucont, rdest_sel, rsrc_sel;
  logic [15:0] imm;
  logic        src_is_imm, reg_we, psr_we, illegal, busy;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_pc;

  // Arithmetic/logic group: ADD SUB AND XOR OR CMP MOV, listed with their ALU code = index.
  logic [3:0] grp_code [7] = '{4'b0101, 4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b1011, 4'b1101};
  bit         grp_sext [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  alu_ctrl_fsm #(.WIDTH(16), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .alucont(alucont), .rdest_sel(rdest_sel),
    .rsrc_sel(rsrc_sel), .imm(imm), .src_is_imm(src_is_imm), .reg_we(reg_we),
    .psr_we(psr_we), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [15:0] w, output bit legal,
                                     output logic [3:0] op, output bit use_imm,
                                     output logic [15:0] imm_v, output bit wr_reg,
                                     output bit wr_psr);
    int k;
    legal = 0; op = 0; use_imm = 0; imm_v = 0; k = -1;
    for (int i = 0; i < 7; i++) begin
      if (w[15:12] == 4'b0000 && w[7:4] == grp_code[i]) begin
        legal = 1; op = 4'(i); k = i;
      end else if (w[15:12] == grp_code[i]) begin
        legal = 1; op = 4'(i); k = i; use_imm = 1;
        imm_v = grp_sext[i] ? 16'(signed'(w[7:0])) : {8'h00, w[7:0]};
      end
    end
    if (w[15:12] == 4'b1000 && w[7:4] == 4'b0100) begin
      legal = 1; op = 4'd7;
    end else if (w[15:12] == 4'b1000 && w[7:5] == 3'b000) begin
      legal = 1; op = 4'd8; use_imm = 1; imm_v = {11'b0, w[4:0]};
    end else if (w[15:12] == 4'b1111) begin
      legal = 1; op = 4'd9; use_imm = 1; imm_v = {w[7:0], 8'h00};
    end
    wr_psr = legal && (k == 0 || k == 1 || k == 5);
    wr_reg = legal && (k != 5);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'(RPC));
    check({tag, "_fetch_req"}, 32'(fetch_req), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_alucont"}, 32'(alucont), 32'd0);
    check({tag, "_imm"}, 32'(imm), 32'd0);
    check({tag, "_sels"}, 32'({rdest_sel, rsrc_sel}), 32'd0);
    check({tag, "_src_is_imm"}, 32'(src_is_imm), 32'd0);
    check({tag, "_strobes"}, 32'({reg_we, psr_we, illegal}), 32'd0);
  endtask

  // Entered just after a negedge with the DUT in FETCH; leaves it the same way.
  task automatic run_instr(input logic [15:0] w, input int gaps, input bit abort_wb);
    bit legal, use_imm, wr_reg, wr_psr;
    logic [3:0] op;
    logic [15:0] imm_v;
    int lat;
    ref_decode(w, legal, op, use_imm, imm_v, wr_reg, wr_psr);
    for (int g = 0; g <= gaps; g++) begin
      check("fetch_req", 32'(fetch_req), 32'd1);
      check("fetch_busy", 32'(busy), 32'd0);
      check("fetch_strobes", 32'({reg_we, psr_we, illegal}), 32'd0);
      check("fetch_pc", 32'(pc), 32'(exp_pc));
      if (g < gaps) begin
        instr_valid = 1'b0;
        instr = 16'($urandom);
        @(negedge clk);
      end
    end
    instr_valid = 1'b1;
    instr = w;
    lat = 1;
    @(negedge clk);
    while (lat <= 4 && !(reg_we || psr_we || illegal)) begin
      instr_valid = 1'($urandom);
      instr = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), legal ? 32'd3 : 32'd2);
    check("wb_busy", 32'(busy), 32'd1);
    check("reg_we", 32'(reg_we), 32'(wr_reg));
    check("psr_we", 32'(psr_we), 32'(wr_psr));
    check("illegal", 32'(illegal), 32'(!legal));
    if (legal) begin
      check("alucont", 32'(alucont), 32'(op));
      check("src_is_imm", 32'(src_is_imm), 32'(use_imm));
      check("rdest_sel", 32'(rdest_sel), 32'(w[11:8]));
      check("rsrc_sel", 32'(rsrc_sel), 32'(w[3:0]));
      if (use_imm) check("imm", 32'(imm), 32'(imm_v));
    end
    $display("instr=%h pc=%h legal=%0d alucont=%h imm=%h reg_we=%0d psr_we=%0d gaps=%0d abort=%0d",
             w, exp_pc, legal, alucont, imm, reg_we, psr_we, gaps, abort_wb);
    if (abort_wb) begin
      reset = 1'b1;
      #1;
      check("abort_strobes", 32'({reg_we, psr_we, illegal}), 32'd0);
      @(negedge clk);
      check("abort_fetch_req", 32'(fetch_req), 32'd0);
      reset = 1'b0;
      instr_valid = 1'b0;
      #1;
      check_reset_values("abort");
      exp_pc = RPC;
    end else begin
      instr_valid = 1'b0;
      @(negedge clk);
      check("strobe_once", 32'({reg_we, psr_we, illegal}), 32'd0);
      exp_pc = exp_pc + 16'd1;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    int c;
    w = 16'($urandom);
    c = $urandom_range(0, 7);
    case (c)
      0: begin w[15:12] = 4'b0000; w[7:4] = grp_code[$urandom_range(0, 6)]; end
      1: w[15:12] = grp_code[$urandom_range(0, 6)];
      2: begin w[15:12] = 4'b1000; w[7:4] = 4'b0100; end
      3: begin w[15:12] = 4'b1000; w[7:5] = 3'b000; end
      4: w[15:12] = 4'b1111;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    reset = 1'b1;
    instr_valid = 1'b1;
    instr = 16'h0351;
    exp_pc = RPC;
    repeat (2) @(negedge clk);
    check("reset_fetch_req", 32'(fetch_req), 32'd0);
    check("reset_strobes", 32'({reg_we, psr_we, illegal}), 32'd0);
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    check_reset_values("reset");

    run_instr(16'h0351, 3, 1'b0);  // ADD after a 3-cycle fetch stall
    run_instr(16'h52FE, 0, 1'b0);  // ADDI -2
    run_instr(16'h12FE, 0, 1'b0);  // ANDI
    run_instr(16'hB4A5, 0, 1'b0);  // CMPI
    run_instr(16'h8613, 1, 1'b0);  // LSHI
    run_instr(16'hF7AB, 0, 1'b0);  // LUI
    run_instr(16'h0E00, 0, 1'b0);  // undecodable
    run_instr(16'h0351, 0, 1'b0);  // crosses 16'hFFFF -> 0000
    run_instr(16'h0351, 0, 1'b0);
    run_instr(16'h0B9A, 0, 1'b1);  // reset lands in WB
    for (int n = 0; n < 300; n++)
      run_instr(rand_instr(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 39) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
